// File: rtl/ifmaps_mac_scheduler.sv
// Ifmap vector scheduler for the MAC array: pops preload vectors,
// frames accumulation tiles, waits out the MAC pipe and hands off results.
module ifmaps_mac_scheduler #(
    parameter int CNT_W   = 16,
    parameter int MAC_LAT = 3,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_acc_len,
    input  logic [CNT_W-1:0]  cfg_num_tiles,
    input  logic              fifo_empty,
    output logic              mac_read,
    output logic              acc_clear,
    output logic              acc_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  tile_idx,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PIPE,
        S_RESULT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0]  ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        LAT_END = 4'(MAC_LAT - 1);
    localparam logic [PERF_W-1:0] STALL_MAX = '1;

    state_t              state_q;
    logic [CNT_W-1:0]    acc_len_q;
    logic [CNT_W-1:0]    num_tiles_q;
    logic [CNT_W-1:0]    vec_cnt_q;
    logic [CNT_W-1:0]    tile_idx_q;
    logic [PERF_W-1:0]   stall_cnt_q;
    logic [3:0]          lat_cnt_q;
    logic                res_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                cfg_err_q;
    logic                cfg_ok;
    logic                vec_first;
    logic                vec_last;

    assign cfg_ok    = (cfg_acc_len != '0) && (cfg_num_tiles != '0);
    assign vec_first = (vec_cnt_q == '0);
    assign vec_last  = (vec_cnt_q == acc_len_q - ONE);

    // Vector pops are combinational so the MAC consumes in the pop cycle
    always_comb begin
        mac_read  = (state_q == S_RUN) & ~fifo_empty;
        acc_clear = mac_read & vec_first;
        acc_last  = mac_read & vec_last;
    end

    // Job sequencing FSM with its counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_len_q   <= '0;
            num_tiles_q <= '0;
            vec_cnt_q   <= '0;
            tile_idx_q  <= '0;
            stall_cnt_q <= '0;
            lat_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            acc_len_q   <= cfg_acc_len;
                            num_tiles_q <= cfg_num_tiles;
                            vec_cnt_q   <= '0;
                            tile_idx_q  <= '0;
                            stall_cnt_q <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_RUN;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (fifo_empty) begin
                        if (stall_cnt_q != STALL_MAX) begin
                            stall_cnt_q <= stall_cnt_q + 1'b1;
                        end
                    end else if (vec_last) begin
                        vec_cnt_q <= '0;
                        lat_cnt_q <= '0;
                        state_q   <= S_PIPE;
                    end else begin
                        vec_cnt_q <= vec_cnt_q + ONE;
                    end
                end
                S_PIPE: begin
                    if (lat_cnt_q == LAT_END) begin
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESULT;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 4'd1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (tile_idx_q == num_tiles_q - ONE) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            tile_idx_q <= tile_idx_q + ONE;
                            state_q    <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign tile_idx  = tile_idx_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ifmaps_mac_scheduler.sv
// Randomized bench for ifmaps_mac_scheduler against a phase-level
// job model plus per-job aggregate checks.
module tb_ifmaps_mac_scheduler;

    localparam int CW   = 4;
    localparam int LAT  = 3;
    localparam int PW   = 4;
    localparam int SMAX = (1 << PW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_PIPE = 2;
    localparam int P_RES  = 3;
    localparam int P_DONE = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] cfg_acc_len;
    logic [CW-1:0] cfg_num_tiles;
    logic          fifo_empty;
    logic          mac_read;
    logic          acc_clear;
    logic          acc_last;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] tile_idx;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [PW-1:0] stall_cnt;

    ifmaps_mac_scheduler #(
        .CNT_W(CW), .MAC_LAT(LAT), .PERF_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_acc_len(cfg_acc_len), .cfg_num_tiles(cfg_num_tiles),
        .fifo_empty(fifo_empty), .mac_read(mac_read),
        .acc_clear(acc_clear), .acc_last(acc_last),
        .res_valid(res_valid), .res_ready(res_ready),
        .tile_idx(tile_idx), .busy(busy), .done(done),
        .cfg_err(cfg_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // model of job progress
    int m_ph = P_IDLE;
    int m_L, m_T, m_vc, m_tile, m_stall, m_pl;
    bit m_err;

    // observation bookkeeping
    int cyc = 0;
    int last_acc = 0;
    bit prev_valid = 0;
    int obs_reads;
    int vcyc = 0;
    int last_hold;
    bit hs_flag;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_vc = 0; m_tile = 0; m_stall = 0; m_err = 0;
    endtask

    task automatic model_tick(input bit st, input int l, input int t,
                              input bit fe, input bit rr);
        bit err_n = 0;
        case (m_ph)
            P_IDLE: if (st) begin
                if (l != 0 && t != 0) begin
                    m_L = l; m_T = t; m_vc = 0; m_tile = 0; m_stall = 0;
                    m_ph = P_RUN;
                end else err_n = 1;
            end
            P_RUN: if (fe) begin
                if (m_stall < SMAX) m_stall++;
            end else if (m_vc == m_L - 1) begin
                m_vc = 0; m_pl = LAT; m_ph = P_PIPE;
            end else m_vc++;
            P_PIPE: begin
                m_pl--;
                if (m_pl == 0) m_ph = P_RES;
            end
            P_RES: if (rr) begin
                if (m_tile == m_T - 1) m_ph = P_DONE;
                else begin m_tile++; m_ph = P_RUN; end
            end
            default: m_ph = P_IDLE;
        endcase
        m_err = err_n;
    endtask

    task automatic step(input bit st, input int l, input int t,
                        input bit fe, input bit rr);
        bit er;
        @(negedge clk);
        start = st; cfg_acc_len = CW'(l); cfg_num_tiles = CW'(t);
        fifo_empty = fe; res_ready = rr;
        #1;
        er = (m_ph == P_RUN) && !fe;
        chk("mac_read", mac_read, er);
        chk("acc_clear", acc_clear, er && m_vc == 0);
        chk("acc_last", acc_last, er && m_vc == m_L - 1);
        chk("res_valid", res_valid, m_ph == P_RES);
        chk("busy", busy, m_ph != P_IDLE);
        chk("done", done, m_ph == P_DONE);
        chk("cfg_err", cfg_err, m_err);
        chk("tile_idx", tile_idx, m_tile);
        chk("stall_cnt", stall_cnt, m_stall);
        cyc++;
        if (mac_read) obs_reads++;
        if (acc_last) last_acc = cyc;
        if (res_valid && !prev_valid) chk("res_lat", cyc - last_acc, LAT + 1);
        prev_valid = res_valid;
        hs_flag = 0;
        if (res_valid) begin
            vcyc++;
            if (rr) begin last_hold = vcyc; vcyc = 0; hs_flag = 1; end
        end
        @(posedge clk);
        model_tick(st, l, t, fe, rr);
    endtask

    // mode 0: clean; 1: random; 2: empty burst at vector 1;
    // 3: ready late by 4 cycles; 4: clean with spurious starts
    task automatic run_job(input int l, input int t, input int mode,
                           input int emp_n);
        int  n = 0;
        int  empt = 0;
        int  rwait = 0;
        bit  fe, rr, st;
        obs_reads = 0;
        vcyc = 0;
        step(1, l, t, 0, 1);
        while (m_ph != P_IDLE && n < 3000) begin
            fe = 0; rr = 1; st = 0;
            case (mode)
                1: begin
                    fe = ($urandom % 4) == 0;
                    rr = $urandom % 2;
                    st = ($urandom % 8) == 0;
                end
                2: begin
                    fe = (m_ph == P_RUN) && m_vc == 1 && empt < emp_n;
                    if (fe) empt++;
                end
                3: rr = (m_ph == P_RES) && rwait == 4;
                4: st = 1;
                default: ;
            endcase
            if (m_ph == P_RES) rwait++; else rwait = 0;
            step(st, $urandom % 16, $urandom % 16, fe, rr);
            if (mode == 3 && hs_flag) chk("hold5", last_hold, 5);
            n++;
        end
        if (m_ph != P_IDLE) chk("timeout", 1, 0);
        chk("job_reads", obs_reads, l * t);
        chk("final_tile", tile_idx, t - 1);
    endtask

    initial begin
        rst_n = 0; start = 0; cfg_acc_len = '0; cfg_num_tiles = '0;
        fifo_empty = 0; res_ready = 0;
        model_reset();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_read", mac_read, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_tile", tile_idx, 0);
        chk("rst_stall", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1;

        run_job(4, 2, 0, 0);
        chk("r035_stall", stall_cnt, 0);
        run_job(3, 1, 2, 5);
        chk("r036_stall", stall_cnt, 5);
        run_job(1, 3, 3, 0);
        step(1, 3, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("r038_busy", busy, 0);
        step(1, 0, 2, 0, 1);
        step(0, 0, 0, 0, 1);
        run_job(3, 2, 4, 0);
        run_job(2, 1, 2, 20);
        chk("stall_sat", stall_cnt, SMAX);
        run_job(15, 15, 0, 0);

        step(1, 2, 2, 0, 1);
        for (int i = 0; i < 200 && !(m_ph == P_PIPE && m_tile == 1); i++)
            step(0, 0, 0, 0, 1);
        chk("reach_pipe1", m_ph == P_PIPE && m_tile == 1, 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("r039_busy", busy, 0);
        chk("r039_read", mac_read, 0);
        chk("r039_tile", tile_idx, 0);
        chk("r039_done", done, 0);
        model_reset();
        prev_valid = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) step(0, 2, 2, 0, 1);

        for (int j = 0; j < 20; j++)
            run_job(1 + $urandom % 6, 1 + $urandom % 6, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
